fetch_ctrl_fsm: RTL and testbench
=================================

// Module: fetch_ctrl_fsm
// PURPOSE
//  Control unit that drives the instruction register / PC datapath of the enhanced processor.
//  Sequences fetch -> decode -> execute and issues IRload, PCload, JMPmux and Meminst to that
//  datapath, plus accumulator and memory controls.
//  Consumes the opcode IR[2:0] returned by the IR register and the A-register status flags.
//  Moore FSM; jump and enter outputs are additionally qualified by live inputs.
// PARAMETERS
//  OP_W   3  opcode width (IR port width)
//  ST_W   4  state register width
//  CNT_W  8  retired-instruction counter width
// PORTS
//  clock      in   1      system clock; all state changes on rising edge
//  Reset      in   1      synchronous, active-high reset
//  IR         in   OP_W   opcode from IR register (IR[7:5] of instruction)
//  Aeq0       in   1      accumulator == 0
//  Apos       in   1      accumulator > 0 (signed, MSB=0 and nonzero)
//  Enter      in   1      user input-valid button (already synchronised)
//  IRload     out  1      load IR from memory data
//  PCload     out  1      load PC (increment or jump target)
//  JMPmux     out  1      1 = PC source is IR[4:0], 0 = PC+1
//  Meminst    out  1      1 = memory address from IR[4:0], 0 = from PC
//  MemWr      out  1      write A to memory
//  Asel       out  2      A input: 00 adder/sub, 01 input port, 10 memory data
//  Aload      out  1      load accumulator
//  Sub        out  1      adder performs A - M
//  Halt       out  1      processor halted
//  InstrCnt   out  CNT_W  count of retired instructions
// BEHAVIOUR
//  - Reset (sync): state=START, Enter_d=0, InstrCnt=0; all control outputs 0. Reset mid-instruction
//    aborts it with no write, load or count.
//  - States: START, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS, HALT.
//  - START: no outputs; next = FETCH.
//  - FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0; next = DECODE.
//  - DECODE: Meminst=1 (operand read issued); next by IR: 000 LOAD, 001 STORE, 010 ADD,
//    011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
//  - LOAD: Asel=10, Aload=1, Meminst=1.
//  - STORE: MemWr=1, Meminst=1.
//  - ADD: Asel=00, Aload=1, Sub=0, Meminst=1.  SUB: same, but Sub=1.
//  - INPUT: Asel=01; holds state until rising edge of Enter (Enter=1 & Enter_d=0).
//    In that cycle Aload=1 and the instruction completes. A held-high Enter never
//    re-triggers a later INPUT.
//  - JZ: if Aeq0, then JMPmux=1 and PCload=1 (Mealy).  JPOS: same, qualified by Apos.
//    Not taken: all 0.
//  - All execute states except INPUT-waiting and HALT return to FETCH next cycle.
//  - HALT: Halt=1; stays in HALT until Reset.
//  - Enter_d <= Enter every cycle, in all states.
//  - InstrCnt +1 on the final cycle of each non-HALT instruction.
//    Wraps 2^CNT_W-1 -> 0; the count does not saturate.
//  - Latency: LOAD/STORE/ADD/SUB/JZ/JPOS take 3 cycles (FETCH, DECODE, EXEC).
//    INPUT takes >= 3 cycles.
//  - Unused state encodings go to START the next cycle, with outputs 0.
// STRUCTURE
//  - Shared package proc_pkg: opcode constants (OP_LOAD..OP_HALT), Asel codes (ASEL_ADD,
//    ASEL_IN, ASEL_MEM), state encodings.
//  - Single module: state register + next-state case + output decode + counter.
//    No sub-module required.
// TESTING
//  1. Reset held 2 cycles, then IR=000 -> FETCH(IRload=1,PCload=1), DECODE(Meminst=1),
//     LOAD(Asel=10,Aload=1); InstrCnt=1.
//  2. IR=101, Aeq0=1 -> JZ cycle JMPmux=1, PCload=1. Repeat with Aeq0=0 -> JMPmux=0,
//     PCload=0; both back to FETCH.
//  3. IR=100, Enter low 5 cycles -> FSM holds INPUT with Aload=0. Enter 0->1 -> Aload=1
//     once. Next INPUT with Enter still high -> waits.
//  4. IR=111 -> Halt=1 held 10 cycles, InstrCnt unchanged. Reset -> Halt=0, state START.
//  5. Reset asserted during ADD cycle -> Aload=0 on the following edge, InstrCnt=0.
//  6. 256 ADD instructions from reset -> InstrCnt wraps to 0; 257th gives 1.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants for the enhanced processor control path:
// opcodes, accumulator source selects and control FSM states.
package proc_pkg;

    localparam int ST_W = 4;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ADD = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_MEM = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_e;

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch/decode/execute sequencer for the enhanced processor datapath.
// Moore outputs per state; jumps and INPUT completion qualified live.
module fetch_ctrl_fsm
    import proc_pkg::*;
#(
    parameter int OP_W  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic [OP_W-1:0]  IR,
    input  logic             Aeq0,
    input  logic             Apos,
    input  logic             Enter,
    output logic             IRload,
    output logic             PCload,
    output logic             JMPmux,
    output logic             Meminst,
    output logic             MemWr,
    output logic [1:0]       Asel,
    output logic             Aload,
    output logic             Sub,
    output logic             Halt,
    output logic [CNT_W-1:0] InstrCnt
);

    state_e           state_q, state_d;
    logic             enter_q, enter_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enter_rise;
    logic             retire;

    assign enter_rise = Enter & ~enter_q;
    assign InstrCnt   = cnt_q;

    // State, Enter history and retired-instruction counter.
    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q <= S_START;
            enter_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, retire strobe and counter update.
    always_comb begin
        state_d = state_q;
        enter_d = Enter;
        retire  = 1'b0;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (IR[2:0])
                    OP_LOAD:  state_d = S_LOAD;
                    OP_STORE: state_d = S_STORE;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_INPUT: state_d = S_INPUT;
                    OP_JZ:    state_d = S_JZ;
                    OP_JPOS:  state_d = S_JPOS;
                    default:  state_d = S_HALT;
                endcase
            end
            S_LOAD, S_STORE, S_ADD,
            S_SUB, S_JZ, S_JPOS: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_INPUT: begin
                if (enter_rise) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_START;
        endcase
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // Datapath controls; forced off while Reset aborts the instruction.
    always_comb begin
        IRload  = 1'b0;
        PCload  = 1'b0;
        JMPmux  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = ASEL_ADD;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Halt    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            S_DECODE: Meminst = 1'b1;
            S_LOAD: begin
                Asel    = ASEL_MEM;
                Aload   = 1'b1;
                Meminst = 1'b1;
            end
            S_STORE: begin
                MemWr   = 1'b1;
                Meminst = 1'b1;
            end
            S_ADD: begin
                Aload   = 1'b1;
                Meminst = 1'b1;
            end
            S_SUB: begin
                Aload   = 1'b1;
                Sub     = 1'b1;
                Meminst = 1'b1;
            end
            S_INPUT: begin
                Asel  = ASEL_IN;
                Aload = enter_rise;
            end
            S_JZ: begin
                JMPmux = Aeq0;
                PCload = Aeq0;
            end
            S_JPOS: begin
                JMPmux = Apos;
                PCload = Apos;
            end
            S_HALT:  Halt = 1'b1;
            default: ;
        endcase
        if (Reset) begin
            IRload  = 1'b0;
            PCload  = 1'b0;
            JMPmux  = 1'b0;
            Meminst = 1'b0;
            MemWr   = 1'b0;
            Asel    = ASEL_ADD;
            Aload   = 1'b0;
            Sub     = 1'b0;
            Halt    = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl_fsm.sv
// Randomized self-checking bench for fetch_ctrl_fsm against an
// instruction-level model of the control sequence.
module tb_fetch_ctrl_fsm;

    localparam int PH_START  = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_EXEC   = 3;

    logic       clock;
    logic       Reset;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic       Enter;
    logic       IRload;
    logic       PCload;
    logic       JMPmux;
    logic       Meminst;
    logic       MemWr;
    logic [1:0] Asel;
    logic       Aload;
    logic       Sub;
    logic       Halt;
    logic [7:0] InstrCnt;

    int checks;
    int errors;
    int cnt_m;
    logic prev_en;
    logic need_start;

    fetch_ctrl_fsm #(.OP_W(3), .CNT_W(8)) dut (
        .clock    (clock),
        .Reset    (Reset),
        .IR       (IR),
        .Aeq0     (Aeq0),
        .Apos     (Apos),
        .Enter    (Enter),
        .IRload   (IRload),
        .PCload   (PCload),
        .JMPmux   (JMPmux),
        .Meminst  (Meminst),
        .MemWr    (MemWr),
        .Asel     (Asel),
        .Aload    (Aload),
        .Sub      (Sub),
        .Halt     (Halt),
        .InstrCnt (InstrCnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    wire [9:0] ctl = {IRload, PCload, JMPmux, Meminst, MemWr,
                      Asel, Aload, Sub, Halt};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // What the datapath should see in a given phase of an instruction.
    function automatic logic [9:0] ref_ctl(input int ph,
                                           input logic [2:0] op,
                                           input logic a0,
                                           input logic ap,
                                           input logic rise);
        logic irl, pcl, jmp, mi, mw, al, sb, hl;
        logic [1:0] as;
        {irl, pcl, jmp, mi, mw, al, sb, hl} = '0;
        as = 2'b00;
        if (ph == PH_FETCH) begin
            irl = 1; pcl = 1;
        end else if (ph == PH_DECODE) begin
            mi = 1;
        end else if (ph == PH_EXEC) begin
            case (op)
                3'd0: begin as = 2'b10; al = 1; mi = 1; end
                3'd1: begin mw = 1; mi = 1; end
                3'd2: begin al = 1; mi = 1; end
                3'd3: begin al = 1; sb = 1; mi = 1; end
                3'd4: begin as = 2'b01; al = rise; end
                3'd5: begin pcl = a0; jmp = a0; end
                3'd6: begin pcl = ap; jmp = ap; end
                default: hl = 1;
            endcase
        end
        return {irl, pcl, jmp, mi, mw, as, al, sb, hl};
    endfunction

    task automatic cycle(input logic rst,
                         input logic [2:0] op,
                         input int ph,
                         input logic en,
                         input logic a0,
                         input logic ap,
                         output logic rise);
        logic [9:0] exp;
        @(negedge clock);
        Reset = rst;
        IR    = op;
        Enter = en;
        Aeq0  = a0;
        Apos  = ap;
        #1;
        rise = en & ~prev_en & ~rst;
        exp  = rst ? 10'd0 : ref_ctl(ph, op, a0, ap, rise);
        chk($sformatf("ctl ph%0d op%0d", ph, op), {22'd0, ctl}, {22'd0, exp});
        chk("cnt", {24'd0, InstrCnt}, cnt_m);
        if (rst) begin
            cnt_m      = 0;
            prev_en    = 1'b0;
            need_start = 1'b1;
        end else begin
            prev_en = en;
        end
    endtask

    task automatic do_reset(input int n);
        logic r;
        for (int i = 0; i < n; i++)
            cycle(1'b1, 3'($urandom), PH_START, 1'($urandom),
                  1'($urandom), 1'($urandom), r);
    endtask

    // One instruction; force_a >= 0 pins Aeq0, abort resets in EXEC.
    task automatic do_instr(input logic [2:0] op,
                            input logic abort,
                            input int force_a);
        logic r, a0, ap;
        a0 = (force_a >= 0) ? force_a[0] : 1'($urandom);
        ap = a0 ? 1'b0 : 1'($urandom);
        if (need_start) begin
            cycle(1'b0, op, PH_START, 1'($urandom), a0, ap, r);
            need_start = 1'b0;
        end
        cycle(1'b0, op, PH_FETCH, 1'($urandom), a0, ap, r);
        cycle(1'b0, op, PH_DECODE, 1'($urandom), a0, ap, r);
        if (op == 3'd7) begin
            for (int i = 0; i < 10; i++)
                cycle(1'b0, op, PH_EXEC, 1'($urandom), a0, ap, r);
        end else if (op == 3'd4) begin
            r = 1'b0;
            for (int k = 0; k < 40 && !r; k++)
                cycle(1'b0, op, PH_EXEC,
                      (k >= 20) ? k[0] : 1'($urandom), a0, ap, r);
            cnt_m = (cnt_m + 1) % 256;
        end else if (abort) begin
            cycle(1'b1, op, PH_EXEC, 1'($urandom), a0, ap, r);
        end else begin
            cycle(1'b0, op, PH_EXEC, 1'($urandom), a0, ap, r);
            cnt_m = (cnt_m + 1) % 256;
        end
    endtask

    initial begin
        logic r;
        logic [2:0] op;
        checks     = 0;
        errors     = 0;
        cnt_m      = 0;
        prev_en    = 1'b0;
        need_start = 1'b1;
        Reset = 1'b1;
        IR    = 3'd0;
        Aeq0  = 1'b0;
        Apos  = 1'b0;
        Enter = 1'b0;
        @(posedge clock);
        do_reset(2);

        do_instr(3'd0, 1'b0, -1);
        do_instr(3'd5, 1'b0, 1);
        do_instr(3'd5, 1'b0, 0);
        do_instr(3'd6, 1'b0, 0);

        cycle(1'b0, 3'd4, PH_FETCH, 1'b0, 1'b0, 1'b0, r);
        cycle(1'b0, 3'd4, PH_DECODE, 1'b0, 1'b0, 1'b0, r);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 3'd4, PH_EXEC, 1'b0, 1'b0, 1'b0, r);
        cycle(1'b0, 3'd4, PH_EXEC, 1'b1, 1'b0, 1'b0, r);
        chk("input_rise", {31'd0, r}, 32'd1);
        cnt_m = (cnt_m + 1) % 256;
        cycle(1'b0, 3'd4, PH_FETCH, 1'b1, 1'b0, 1'b0, r);
        cycle(1'b0, 3'd4, PH_DECODE, 1'b1, 1'b0, 1'b0, r);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 3'd4, PH_EXEC, 1'b1, 1'b0, 1'b0, r);
        cycle(1'b0, 3'd4, PH_EXEC, 1'b0, 1'b0, 1'b0, r);
        cycle(1'b0, 3'd4, PH_EXEC, 1'b1, 1'b0, 1'b0, r);
        cnt_m = (cnt_m + 1) % 256;

        do_instr(3'd7, 1'b0, -1);
        do_reset(1);
        do_instr(3'd2, 1'b1, -1);
        do_instr(3'd3, 1'b0, -1);

        do_reset(1);
        for (int i = 0; i < 256; i++)
            do_instr(3'd2, 1'b0, -1);
        @(posedge clock);
        #1;
        chk("wrap0", {24'd0, InstrCnt}, 32'd0);
        do_instr(3'd2, 1'b0, -1);
        @(posedge clock);
        #1;
        chk("wrap1", {24'd0, InstrCnt}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 6));
            if (i % 50 == 49) begin
                do_instr(3'd7, 1'b0, -1);
                do_reset(1 + int'($urandom_range(0, 1)));
            end else begin
                do_instr(op, ($urandom_range(0, 19) == 0), -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
